// File: rtl/fetch_sequencer_pkg.sv
// Shared state encodings and constants for the fetch sequencer and its phase ring.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_RST_WAIT = 2'd0,
    SEQ_FETCH    = 2'd1,
    SEQ_EXEC     = 2'd2
  } seqState_e;

  localparam int PHASE_FETCH      = 0;
  localparam int DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_sequencer_phase_ring.sv
// One-hot phase rotator: holds by default, rotates on advance, snaps to the fetch bit on loadFetch.
module fetch_sequencer_phase_ring
  import fetch_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = 5
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  advance,
  input  logic                  loadFetch,
  output logic [NUM_PHASES-1:0] phase
);

  localparam logic [NUM_PHASES-1:0] FETCH_ONEHOT = NUM_PHASES'(1) << PHASE_FETCH;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      phase <= FETCH_ONEHOT;
    end else if (loadFetch) begin
      phase <= FETCH_ONEHOT;
    end else if (advance) begin
      phase <= {phase[NUM_PHASES-2:0], phase[NUM_PHASES-1]};
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: req/ack instruction fetch, one-hot execute phases, PC and retire counter.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              ADDR_W     = 8,
  parameter int              INST_W     = 25,
  parameter int              NUM_PHASES = 5,   // legal range 3..16
  parameter int              CNT_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  Reset,
  output logic                  imem_req,
  output logic [ADDR_W-1:0]     imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_W-1:0]     imem_data,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_addr,
  output logic [NUM_PHASES-1:0] phase,
  output logic [INST_W-1:0]     inst,
  output logic                  inst_valid,
  output logic [ADDR_W-1:0]     pc,
  output logic [ADDR_W-1:0]     pc_plus1,
  output logic [CNT_W-1:0]      retire_cnt
);

  seqState_e         state;
  logic              reqQ;
  logic [ADDR_W-1:0] pcQ;
  logic [INST_W-1:0] instQ;
  logic              instValidQ;
  logic [CNT_W-1:0]  retireQ;

  logic fetchDone;
  logic inExec;
  logic lastPhase;
  logic execStep;
  logic retireNow;

  // reqQ is only ever high in FETCH, so an ack outside a request falls through.
  assign fetchDone = reqQ & imem_ack;
  assign inExec    = (state == SEQ_EXEC);
  assign lastPhase = phase[NUM_PHASES-1];
  assign execStep  = inExec & ~stall & ~lastPhase;
  assign retireNow = inExec & ~stall & lastPhase;

  fetch_sequencer_phase_ring #(
    .NUM_PHASES(NUM_PHASES)
  ) u_phase_ring (
    .clk      (clk),
    .Reset    (Reset),
    .advance  (fetchDone | execStep),
    .loadFetch(retireNow),
    .phase    (phase)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state      <= SEQ_RST_WAIT;
      reqQ       <= 1'b0;
      pcQ        <= RESET_PC;
      instQ      <= '0;
      instValidQ <= 1'b0;
      retireQ    <= '0;
    end else begin
      case (state)
        SEQ_RST_WAIT: begin
          state <= SEQ_FETCH;
          reqQ  <= 1'b1;
        end
        SEQ_FETCH: begin
          if (fetchDone) begin
            instQ      <= imem_data;
            instValidQ <= 1'b1;
            reqQ       <= 1'b0;
            state      <= SEQ_EXEC;
          end
        end
        SEQ_EXEC: begin
          // Redirects are only honoured on the edge that retires the instruction.
          if (retireNow) begin
            pcQ        <= redirect_valid ? redirect_addr : pcQ + ADDR_W'(1);
            retireQ    <= retireQ + CNT_W'(1);
            instValidQ <= 1'b0;
            reqQ       <= 1'b1;
            state      <= SEQ_FETCH;
          end
        end
        default: begin
          state <= SEQ_RST_WAIT;
          reqQ  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = reqQ;
  assign imem_addr  = pcQ;
  assign pc         = pcQ;
  assign pc_plus1   = pcQ + ADDR_W'(1);
  assign inst       = instQ;
  assign inst_valid = instValidQ;
  assign retire_cnt = retireQ;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: 5-phase build plus a 3-phase build sharing clock and reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic [24:0] imem_data = '0;

  logic        imem_ack = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [7:0]  redirect_addr = '0;
  logic        imem_req, inst_valid;
  logic [7:0]  imem_addr, pc, pc_plus1;
  logic [4:0]  phase;
  logic [24:0] inst;
  logic [15:0] retire_cnt;

  logic        ack3 = 1'b0, stall3 = 1'b0, redirect3 = 1'b0;
  logic [7:0]  redirAddr3 = '0;
  logic        req3, instValid3;
  logic [7:0]  addr3, pc3, pcPlus3;
  logic [2:0]  phase3;
  logic [24:0] inst3;
  logic [15:0] retire3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .Reset(Reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .phase(phase), .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .pc_plus1(pc_plus1), .retire_cnt(retire_cnt)
  );

  fetch_sequencer #(.NUM_PHASES(3)) dut3 (
    .clk(clk), .Reset(Reset),
    .imem_req(req3), .imem_addr(addr3), .imem_ack(ack3), .imem_data(imem_data),
    .stall(stall3), .redirect_valid(redirect3), .redirect_addr(redirAddr3),
    .phase(phase3), .inst(inst3), .inst_valid(instValid3),
    .pc(pc3), .pc_plus1(pcPlus3), .retire_cnt(retire3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one 5-phase instruction with a zero-wait fetch; ends one step into the next FETCH.
  task automatic run_instr(input logic doRedirect, input logic [7:0] target);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick(); tick(); tick();
    redirect_valid = doRedirect;
    redirect_addr  = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    @(negedge clk); @(negedge clk);
    Reset = 1'b1;
    tick();
    imem_data = 25'h0ABCDE;
    imem_ack  = 1'b1;
    tick();
    imem_ack  = 1'b0;
    tick();
    checks++; if (phase !== 5'b00100) begin failures++; $display("FAIL pre_reset_exec2 phase got=%b exp=%b", phase, 5'b00100); end
    Reset = 1'b0;
    #1;
    checks++; if (phase !== 5'b00001) begin failures++; $display("FAIL reset_phase got=%b exp=%b", phase, 5'b00001); end
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 8'h00); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=%b", imem_req, 1'b0); end
    checks++; if (inst !== 25'h0) begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst, 25'h0); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=%b", inst_valid, 1'b0); end
    checks++; if (retire_cnt !== 16'h0) begin failures++; $display("FAIL reset_retire got=%h exp=%h", retire_cnt, 16'h0); end
    @(negedge clk);
    Reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_wait_req got=%b exp=%b", imem_req, 1'b0); end
    checks++; if (phase !== 5'b00001) begin failures++; $display("FAIL rst_wait_phase got=%b exp=%b", phase, 5'b00001); end
    tick();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_fetch_req got=%b exp=%b", imem_req, 1'b1); end
    checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL first_fetch_addr got=%h exp=%h", imem_addr, 8'h00); end
  endtask

  task automatic test_back_to_back();
    logic [24:0] dat [2];
    logic [4:0]  expPhase;
    dat[0] = 25'h1111111;
    dat[1] = 25'h0222222;
    for (int i = 0; i < 2; i++) begin
      imem_data = dat[i];
      imem_ack  = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        tick();
        expPhase = (k == 5) ? 5'b00001 : 5'(1 << k);
        checks++; if (phase !== expPhase) begin failures++; $display("FAIL b2b_phase i=%0d k=%0d got=%b exp=%b", i, k, phase, expPhase); end
        if (k == 1) begin
          checks++; if (inst !== dat[i]) begin failures++; $display("FAIL b2b_inst i=%0d got=%h exp=%h", i, inst, dat[i]); end
          checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid i=%0d got=%b exp=%b", i, inst_valid, 1'b1); end
        end
      end
      checks++; if (pc !== 8'(i + 1)) begin failures++; $display("FAIL b2b_pc i=%0d got=%h exp=%h", i, pc, 8'(i + 1)); end
      checks++; if (retire_cnt !== 16'(i + 1)) begin failures++; $display("FAIL b2b_retire i=%0d got=%0d exp=%0d", i, retire_cnt, i + 1); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop i=%0d got=%b exp=%b", i, inst_valid, 1'b0); end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_wait_states();
    imem_data = 25'h0C0FFEE;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h02) begin failures++; $display("FAIL wait_hold0 req=%b addr=%h exp req=1 addr=02", imem_req, imem_addr); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h02 || phase !== 5'b00001) begin
        failures++; $display("FAIL wait_hold%0d req=%b addr=%h phase=%b exp req=1 addr=02 phase=00001", i, imem_req, imem_addr, phase);
      end
    end
    imem_ack = 1'b1;
    tick();
    checks++; if (inst !== 25'h0C0FFEE) begin failures++; $display("FAIL wait_inst got=%h exp=%h", inst, 25'h0C0FFEE); end
    checks++; if (phase !== 5'b00010) begin failures++; $display("FAIL wait_exec1 got=%b exp=%b", phase, 5'b00010); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wait_req_drop got=%b exp=%b", imem_req, 1'b0); end
    imem_data = 25'h1DEAD00;
    tick();
    imem_ack = 1'b0;
    checks++; if (inst !== 25'h0C0FFEE) begin failures++; $display("FAIL spurious_ack_inst got=%h exp=%h", inst, 25'h0C0FFEE); end
    checks++; if (phase !== 5'b00100) begin failures++; $display("FAIL spurious_ack_phase got=%b exp=%b", phase, 5'b00100); end
    tick(); tick(); tick();
    checks++; if (pc !== 8'h03 || retire_cnt !== 16'd3) begin failures++; $display("FAIL wait_retire pc=%h cnt=%0d exp pc=03 cnt=3", pc, retire_cnt); end
  endtask

  task automatic test_stall();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (phase !== 5'b00100) begin failures++; $display("FAIL stall_exec2 cyc=%0d got=%b exp=%b", i, phase, 5'b00100); end
    end
    stall = 1'b0;
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (phase !== 5'b10000 || pc !== 8'h03 || retire_cnt !== 16'd3) begin
        failures++; $display("FAIL stall_exec4 cyc=%0d phase=%b pc=%h cnt=%0d exp phase=10000 pc=03 cnt=3", i, phase, pc, retire_cnt);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (phase !== 5'b00001 || pc !== 8'h04 || retire_cnt !== 16'd4) begin
      failures++; $display("FAIL stall_release phase=%b pc=%h cnt=%0d exp phase=00001 pc=04 cnt=4", phase, pc, retire_cnt);
    end
  endtask

  task automatic test_redirect();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 8'h40;
    tick();
    redirect_valid = 1'b0;
    checks++; if (phase !== 5'b01000) begin failures++; $display("FAIL early_redirect_phase got=%b exp=%b", phase, 5'b01000); end
    tick(); tick();
    checks++; if (imem_addr !== 8'h05) begin failures++; $display("FAIL early_redirect_ignored got=%h exp=%h", imem_addr, 8'h05); end
    run_instr(1'b1, 8'h40);
    checks++; if (imem_addr !== 8'h40) begin failures++; $display("FAIL redirect_addr got=%h exp=%h", imem_addr, 8'h40); end
    checks++; if (pc_plus1 !== 8'h41) begin failures++; $display("FAIL redirect_pc_plus1 got=%h exp=%h", pc_plus1, 8'h41); end
    checks++; if (retire_cnt !== 16'd6) begin failures++; $display("FAIL redirect_retire got=%0d exp=%0d", retire_cnt, 6); end
    run_instr(1'b1, 8'h40);
    checks++; if (pc !== 8'h40 || retire_cnt !== 16'd7) begin failures++; $display("FAIL self_loop pc=%h cnt=%0d exp pc=40 cnt=7", pc, retire_cnt); end
  endtask

  task automatic test_wrap();
    run_instr(1'b1, 8'hFF);
    checks++; if (pc !== 8'hFF) begin failures++; $display("FAIL wrap_setup pc got=%h exp=%h", pc, 8'hFF); end
    checks++; if (pc_plus1 !== 8'h00) begin failures++; $display("FAIL wrap_pc_plus1 got=%h exp=%h", pc_plus1, 8'h00); end
    run_instr(1'b0, 8'h00);
    checks++; if (pc !== 8'h00 || pc_plus1 !== 8'h01) begin failures++; $display("FAIL wrap_pc pc=%h plus1=%h exp pc=00 plus1=01", pc, pc_plus1); end
    checks++; if (retire_cnt !== 16'd9) begin failures++; $display("FAIL wrap_retire got=%0d exp=%0d", retire_cnt, 9); end
  endtask

  task automatic test_three_phase();
    logic [2:0] expPhase;
    for (int i = 0; i < 2; i++) begin
      ack3 = 1'b1;
      for (int k = 1; k <= 3; k++) begin
        tick();
        expPhase = (k == 3) ? 3'b001 : 3'(1 << k);
        checks++; if (phase3 !== expPhase) begin failures++; $display("FAIL p3_phase i=%0d k=%0d got=%b exp=%b", i, k, phase3, expPhase); end
      end
      checks++; if (pc3 !== 8'(i + 1) || retire3 !== 16'(i + 1)) begin
        failures++; $display("FAIL p3_retire i=%0d pc=%h cnt=%0d exp pc=%0d cnt=%0d", i, pc3, retire3, i + 1, i + 1);
      end
    end
    ack3 = 1'b1;
    tick();
    ack3 = 1'b0;
    stall3 = 1'b1;
    tick(); tick();
    checks++; if (phase3 !== 3'b010) begin failures++; $display("FAIL p3_stall_exec1 got=%b exp=%b", phase3, 3'b010); end
    stall3 = 1'b0;
    tick();
    stall3 = 1'b1;
    tick(); tick();
    checks++; if (phase3 !== 3'b100 || pc3 !== 8'h02) begin failures++; $display("FAIL p3_stall_last phase=%b pc=%h exp phase=100 pc=02", phase3, pc3); end
    stall3 = 1'b0;
    tick();
    checks++; if (phase3 !== 3'b001 || pc3 !== 8'h03 || retire3 !== 16'd3) begin
      failures++; $display("FAIL p3_stall_release phase=%b pc=%h cnt=%0d exp phase=001 pc=03 cnt=3", phase3, pc3, retire3);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_stall();
    test_redirect();
    test_wrap();
    test_three_phase();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
